// File: rtl/priority_service_sched_v.sv
// Fixed-priority request scheduler: offer, handshake, then a fixed-length service window.
// Optional saturating overflow counter enabled by PRIORITY_SERVICE_SCHED_OVF_EN.
module priority_service_sched_v #(
  parameter int unsigned SERVICE_CYCLES = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_ready,
  output logic [1:0] o_code,
  output logic       o_valid,
  output logic       o_busy,
  output logic [3:0] o_pending,
  output logic [7:0] o_ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    SERVICE
  } state_t;

  state_t     state;
  logic [3:0] pend;
  logic [3:0] cnt;
  logic [3:0] clr;
  logic [1:0] low;
  logic       hs;

  assign hs = o_valid & i_ready;

  always_comb begin
    clr = '0;
    if (hs) clr[o_code] = 1'b1;
  end

  always_comb begin
    low = 2'd0;
    priority case (1'b1)
      pend[0]: low = 2'd0;
      pend[1]: low = 2'd1;
      pend[2]: low = 2'd2;
      pend[3]: low = 2'd3;
      default: low = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr) | i_req;
    end
  end

  assign o_pending = pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      o_code  <= '0;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pend != '0) begin
            o_code  <= low;
            o_valid <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (i_ready) begin
            cnt     <= 4'(SERVICE_CYCLES - 1);
            o_valid <= 1'b0;
            o_busy  <= 1'b1;
            state   <= SERVICE;
          end
        end
        SERVICE: begin
          if (cnt == '0) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef PRIORITY_SERVICE_SCHED_OVF_EN
  logic [7:0] ovf;

  // re-request on a line that stays pending this cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf <= '0;
    end else if (|(i_req & pend & ~clr) && ovf != 8'hff) begin
      ovf <= ovf + 8'd1;
    end
  end

  assign o_ovf_cnt = ovf;
`else
  assign o_ovf_cnt = '0;
`endif

endmodule
